// File: rtl/rram_pulse_seq_if.sv
// ---------------------------------------------------------------------------
// rram_pulse_seq_if
//   Wishbone B4 classic slave bundle used by rram_pulse_seq. Signal names keep
//   the Caravel wbs_* spelling so the wrapper can wire the bus straight through.
//
//   wbs_stb_i  strobe            wbs_cyc_i  cycle
//   wbs_we_i   write enable      wbs_sel_i  byte lanes (full-word only)
//   wbs_adr_i  byte address      wbs_dat_i  write data
//   wbs_ack_o  acknowledge       wbs_dat_o  read data
//
//   master: the bus side (drives stb/cyc/we/sel/adr/dat_i)
//   slave : the sequencer side (drives ack/dat_o)
// ---------------------------------------------------------------------------
interface rram_pulse_seq_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/rram_pulse_seq.sv
// ---------------------------------------------------------------------------
// rram_pulse_seq
//   Wishbone-controlled pulse sequencer for the RRAM array drivers. Software
//   programs the operation, cell address and setup/pulse timing, then writes
//   start. The block selects one word line and one bit line, drives the op
//   mode, fires a timed pulse enable, samples the sense amp on READ and flags
//   completion through STATUS.done and a level interrupt.
//
//   Register map (word offsets from BASE_ADR, decoded on adr[31:4]):
//     0x0 CTRL   [1:0] op, [2] start (write-1, reads 0), [3] irq_en
//     0x4 ADDR   [ROW_W-1:0] row, [ROW_W+COL_W-1:ROW_W] col
//     0x8 TIMING [CNT_W-1:0] pulse_w, [16+CNT_W-1:16] setup_w
//     0xC STATUS [0] busy, [1] done (W1C), [2] rd_bit, [3] err (W1C)
//
// Ports
//   wb_clk_i   clock, all logic on the rising edge
//   wb_rst_ni  asynchronous active-low reset
//   wb         Wishbone slave bundle (rram_pulse_seq_if.slave)
//   sa_out     sense-amp output, stable during PULSE of a READ
//   wl_sel     one-hot word-line select
//   bl_sel     one-hot bit-line select
//   op_mode    0 READ, 1 SET, 2 RESET, 3 FORM
//   pulse_en   driver pulse enable
//   sa_en      sense-amp enable (READ only)
//   irq        level interrupt, done & irq_en
// ---------------------------------------------------------------------------
module rram_pulse_seq #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          ROW_W    = 3,
    parameter int          COL_W    = 3,
    parameter int          CNT_W    = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    rram_pulse_seq_if.slave       wb,
    input  logic                  sa_out,
    output logic [2**ROW_W-1:0]   wl_sel,
    output logic [2**COL_W-1:0]   bl_sel,
    output logic [1:0]            op_mode,
    output logic                  pulse_en,
    output logic                  sa_en,
    output logic                  irq
);

    localparam int NW = 2**ROW_W;
    localparam int NB = 2**COL_W;

    localparam logic [NW-1:0]    WL_ONE  = NW'(1);
    localparam logic [NB-1:0]    BL_ONE  = NB'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] OP_READ    = 2'd0;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_ADDR   = 2'd1;
    localparam logic [1:0] OFF_TIMING = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Register file and bus-side state
    // ------------------------------------------------------------------
    logic             ack_q;
    logic [31:0]      dat_q;
    logic [1:0]       ctrl_op;
    logic             ctrl_irq_en;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [CNT_W-1:0] pulse_w_q;
    logic [CNT_W-1:0] setup_w_q;
    logic             start_req;   // start accepted, waiting for the FSM to pick it up
    logic             err_q;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sh_op;
    logic [CNT_W-1:0] sh_pulse_w;
    logic             busy_q;
    logic             done_q;
    logic             rd_bit_q;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        access;
    logic        hit;
    logic        wr_hit;
    logic        rd_hit;
    logic [1:0]  off;
    logic        cfg_wr;
    logic        busy_any;
    logic        collide;
    logic        done_clr;
    logic        err_clr;
    logic        start_go;
    logic [31:0] rdata;

    // A new access is only taken while ack is low, which gives exactly one
    // ack cycle per access and no wait states.
    assign access   = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    assign hit      = (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign off      = wb.wbs_adr_i[3:2];
    assign wr_hit   = access & wb.wbs_we_i & hit;
    assign rd_hit   = access & ~wb.wbs_we_i & hit;
    assign cfg_wr   = wr_hit & (off != OFF_STATUS);

    // A pending start counts as busy so a config write landing between the
    // start ack and SETUP entry cannot alter the parameters being shadowed.
    assign busy_any = busy_q | start_req;
    assign collide  = cfg_wr & busy_any;
    assign done_clr = wr_hit & (off == OFF_STATUS) & wb.wbs_dat_i[1];
    assign err_clr  = wr_hit & (off == OFF_STATUS) & wb.wbs_dat_i[3];
    assign start_go = (state == S_IDLE) & start_req;

    // Byte lanes and the sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0]};

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL: begin
                rdata[1:0] = ctrl_op;
                rdata[3]   = ctrl_irq_en;
            end
            OFF_ADDR: begin
                rdata[ROW_W-1:0]           = row_q;
                rdata[ROW_W+COL_W-1:ROW_W] = col_q;
            end
            OFF_TIMING: begin
                rdata[CNT_W-1:0]     = pulse_w_q;
                rdata[16+CNT_W-1:16] = setup_w_q;
            end
            default: begin
                rdata[3:0] = {err_q, rd_bit_q, done_q, busy_q};
            end
        endcase
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    // A zero width still has to last one cycle, so the counter reload is
    // max(w,1)-1 and the state advances when the counter reaches zero.
    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] w);
        return (w == '0) ? '0 : (w - CNT_ONE);
    endfunction

    // ------------------------------------------------------------------
    // Wishbone slave and configuration registers
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            ctrl_op     <= '0;
            ctrl_irq_en <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            pulse_w_q   <= '0;
            setup_w_q   <= '0;
            start_req   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= access;
            // Unmapped reads and all writes return zero on the data bus.
            dat_q <= rd_hit ? rdata : '0;

            if (start_go) begin
                start_req <= 1'b0;
            end

            if (cfg_wr && !busy_any) begin
                case (off)
                    OFF_CTRL: begin
                        ctrl_op     <= wb.wbs_dat_i[1:0];
                        ctrl_irq_en <= wb.wbs_dat_i[3];
                        start_req   <= wb.wbs_dat_i[2];
                    end
                    OFF_ADDR: begin
                        row_q <= wb.wbs_dat_i[ROW_W-1:0];
                        col_q <= wb.wbs_dat_i[ROW_W+COL_W-1:ROW_W];
                    end
                    OFF_TIMING: begin
                        pulse_w_q <= wb.wbs_dat_i[CNT_W-1:0];
                        setup_w_q <= wb.wbs_dat_i[16+CNT_W-1:16];
                    end
                    default: ;
                endcase
            end

            if (collide) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pulse sequencer: IDLE -> SETUP -> PULSE -> SAMPLE -> DONE -> IDLE
    // All array-side outputs are registered and change on state entry.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sh_op      <= '0;
            sh_pulse_w <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_bit_q   <= 1'b0;
            wl_sel     <= '0;
            bl_sel     <= '0;
            op_mode    <= '0;
            pulse_en   <= 1'b0;
            sa_en      <= 1'b0;
        end else begin
            // The FSM assignments below come later in the block, so a done
            // set on DONE entry overrides a W1C arriving in the same cycle.
            if (done_clr) begin
                done_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_go) begin
                        // The selects themselves hold the row/col snapshot;
                        // setup_w is consumed into the counter right here.
                        sh_op      <= ctrl_op;
                        sh_pulse_w <= pulse_w_q;
                        cnt        <= reload(setup_w_q);
                        wl_sel     <= WL_ONE << row_q;
                        bl_sel     <= BL_ONE << col_q;
                        op_mode    <= ctrl_op;
                        sa_en      <= (ctrl_op == OP_READ);
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state      <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt == '0) begin
                        cnt      <= reload(sh_pulse_w);
                        pulse_en <= 1'b1;
                        state    <= S_PULSE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_PULSE: begin
                    if (cnt == '0) begin
                        pulse_en <= 1'b0;
                        // sa_out is taken on the last PULSE cycle, while the
                        // cell is still biased.
                        if (sh_op == OP_READ) begin
                            rd_bit_q <= sa_out;
                        end
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_SAMPLE: begin
                    wl_sel  <= '0;
                    bl_sel  <= '0;
                    op_mode <= '0;
                    sa_en   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state   <= S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq = done_q & ctrl_irq_en;

endmodule

// File: tb/tb_rram_pulse_seq.sv
// ---------------------------------------------------------------------------
// tb_rram_pulse_seq
//   Scoreboard bench for rram_pulse_seq. Stimulus tasks push the expected
//   Wishbone response (and, for a start write, the expected pulse sequence)
//   into queues; one monitor on the falling edge pops and compares whenever
//   the DUT acks, and follows the array outputs of each sequence against the
//   timing rules: latency max(s,1)+max(p,1)+2, pulse after max(s,1) setup
//   cycles, pulse width max(p,1), one-hot selects held until DONE.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rram_pulse_seq;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sa_out = 1'b0;
    logic [7:0] wl_sel;
    logic [7:0] bl_sel;
    logic [1:0] op_mode;
    logic       pulse_en;
    logic       sa_en;
    logic       irq;

    rram_pulse_seq_if wb_bus ();

    rram_pulse_seq #(.BASE_ADR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb        (wb_bus),
        .sa_out    (sa_out),
        .wl_sel    (wl_sel),
        .bl_sel    (bl_sel),
        .op_mode   (op_mode),
        .pulse_en  (pulse_en),
        .sa_en     (sa_en),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic        is_start;
        logic [31:0] exp;
        string       name;
    } wb_exp_t;

    typedef struct {
        int   row;
        int   col;
        int   op;
        int   sw;
        int   pw;
        logic irq_en;
    } seq_exp_t;

    wb_exp_t  wb_q[$];
    seq_exp_t seq_q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference register model
    int   m_op = 0, m_row = 0, m_col = 0, m_sw = 0, m_pw = 0;
    logic m_irq_en = 1'b0, m_done = 1'b0, m_err = 1'b0, m_rd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event missing at %0t", name, $time);
    endtask

    function automatic int at_least_1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic logic [31:0] status_exp(input logic busy);
        return {28'd0, m_err, m_rd, m_done, busy};
    endfunction

    // ------------------------------------------------------------------
    // Monitor: Wishbone scoreboard plus sequence tracker
    // ------------------------------------------------------------------
    int       cyc_n = 0;
    logic     ack_prev = 1'b0;
    logic     active = 1'b0;
    seq_exp_t cur;
    int       t_ack, pulse_start, pulse_n, rel;
    logic     pulse_over, sel_ok;
    logic [7:0] exp_wl, exp_bl;

    always @(negedge clk) begin
        if (!rst_n) begin
            active   = 1'b0;
            ack_prev = 1'b0;
        end else begin
            cyc_n++;
            if (wb_bus.wbs_ack_o) begin
                check("ack_single_cycle", ack_prev, 1'b0);
                if (wb_q.size() == 0) begin
                    fail("unexpected_ack");
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    if (e.is_read) check(e.name, wb_bus.wbs_dat_o, e.exp);
                    if (e.is_start) begin
                        if (seq_q.size() == 0) begin
                            fail("start_without_model");
                        end else begin
                            cur         = seq_q.pop_front();
                            active      = 1'b1;
                            t_ack       = cyc_n;
                            pulse_n     = 0;
                            pulse_start = -1;
                            pulse_over  = 1'b0;
                            sel_ok      = 1'b1;
                            exp_wl      = 8'd1 << cur.row;
                            exp_bl      = 8'd1 << cur.col;
                        end
                    end
                end
            end
            ack_prev = wb_bus.wbs_ack_o;

            if (active) begin
                rel = cyc_n - t_ack;
                if (rel >= 1) begin
                    if (!pulse_en && pulse_n > 0) pulse_over = 1'b1;
                    if (!pulse_over) begin
                        if (wl_sel !== exp_wl || bl_sel !== exp_bl ||
                            op_mode !== 2'(cur.op) || sa_en !== (cur.op == 0))
                            sel_ok = 1'b0;
                        if (pulse_en) begin
                            if (pulse_n == 0) pulse_start = rel;
                            pulse_n++;
                        end
                    end else begin
                        if (pulse_en) sel_ok = 1'b0;
                        if (wl_sel == 8'd0) begin
                            check("latency", rel, at_least_1(cur.sw) + at_least_1(cur.pw) + 2);
                            check("pulse_start", pulse_start, at_least_1(cur.sw) + 1);
                            check("pulse_width", pulse_n, at_least_1(cur.pw));
                            check("selects_held", sel_ok, 1'b1);
                            check("done_cleared", {bl_sel, sa_en, pulse_en}, 10'd0);
                            check("irq_at_done", irq, cur.irq_en);
                            active = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (called right after a rising edge)
    // ------------------------------------------------------------------
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic is_start, input logic [31:0] exp, input string name);
        wb_exp_t e;
        e.is_read  = !we;
        e.is_start = is_start;
        e.exp      = exp;
        e.name     = name;
        wb_q.push_back(e);
        wb_bus.wbs_stb_i = 1'b1;
        wb_bus.wbs_cyc_i = 1'b1;
        wb_bus.wbs_we_i  = we;
        wb_bus.wbs_sel_i = 4'hf;
        wb_bus.wbs_adr_i = adr;
        wb_bus.wbs_dat_i = dat;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb_bus.wbs_stb_i = 1'b0;
        wb_bus.wbs_cyc_i = 1'b0;
        wb_bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] dat);
        wb_xfer(1'b1, BASE + off, dat, 1'b0, 32'd0, "write");
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        wb_xfer(1'b0, BASE + off, 32'd0, 1'b0, exp, name);
    endtask

    task automatic wait_seq();
        for (int i = 0; i < 3000 && (active || seq_q.size() != 0); i++) @(posedge clk);
        if (active || seq_q.size() != 0) begin
            fail("sequence_timeout");
            seq_q.delete();
        end
        #1;
    endtask

    task automatic wait_pulse();
        for (int i = 0; i < 200 && !pulse_en; i++) @(negedge clk);
        if (!pulse_en) fail("pulse_timeout");
    endtask

    // Programs ADDR/TIMING then writes CTRL with start; returns after start ack.
    task automatic launch(input int op, input int row, input int col, input int sw,
                          input int pw, input logic ien, input logic sa);
        seq_exp_t s;
        m_op = op; m_row = row; m_col = col; m_sw = sw; m_pw = pw; m_irq_en = ien;
        sa_out = sa;
        wr(32'h4, 32'((col << 3) | row));
        wr(32'h8, 32'((sw << 16) | pw));
        s.row = row; s.col = col; s.op = op; s.sw = sw; s.pw = pw; s.irq_en = ien;
        seq_q.push_back(s);
        m_done = 1'b0;
        wb_xfer(1'b1, BASE, 32'(op | 4 | (ien << 3)), 1'b1, 32'd0, "start");
    endtask

    task automatic finish_seq();
        wait_seq();
        m_done = 1'b1;
        if (m_op == 0) m_rd = sa_out;
        rd(32'hC, status_exp(1'b0), "status_after_seq");
    endtask

    task automatic run_seq(input int op, input int row, input int col, input int sw,
                           input int pw, input logic ien, input logic sa);
        launch(op, row, col, sw, pw, ien, sa);
        finish_seq();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        wb_bus.wbs_stb_i = 1'b0;
        wb_bus.wbs_cyc_i = 1'b0;
        wb_bus.wbs_we_i  = 1'b0;
        wb_bus.wbs_sel_i = 4'h0;
        wb_bus.wbs_adr_i = 32'd0;
        wb_bus.wbs_dat_i = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {wl_sel, bl_sel, op_mode, pulse_en, sa_en, irq}, 21'd0);
        check("rst_wb", {wb_bus.wbs_ack_o, wb_bus.wbs_dat_o}, 33'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(32'h0, 32'd0, "rst_ctrl");
        rd(32'hC, 32'd0, "rst_status");

        // SET row5/col2, setup 3 / pulse 10
        run_seq(1, 5, 2, 3, 10, 1'b0, 1'b0);
        check("set_irq_disabled", irq, 1'b0);
        wr(32'hC, 32'h2); m_done = 1'b0;

        // READ with sa_out=1 and irq enabled; STATUS 0x6
        run_seq(0, 3, 6, 2, 4, 1'b1, 1'b1);
        check("read_irq_set", irq, 1'b1);
        wr(32'hC, 32'h2); m_done = 1'b0;
        check("read_irq_w1c", irq, 1'b0);
        rd(32'hC, 32'h4, "status_after_w1c");

        // Zero timing: latency 4
        run_seq(2, 0, 7, 0, 0, 1'b0, 1'b0);
        wr(32'hC, 32'h2); m_done = 1'b0;

        // Busy collision during PULSE
        launch(1, 1, 6, 2, 24, 1'b0, 1'b0);
        wait_pulse();
        @(posedge clk); #1;
        wr(32'h4, 32'h3F);
        wb_xfer(1'b1, BASE, 32'h5, 1'b0, 32'd0, "start_while_busy");
        m_err = 1'b1;
        rd(32'hC, status_exp(1'b1), "status_busy_err");
        rd(32'h4, 32'((m_col << 3) | m_row), "addr_unchanged");
        finish_seq();
        wr(32'hC, 32'hA); m_done = 1'b0; m_err = 1'b0;
        rd(32'hC, status_exp(1'b0), "status_after_w1c_both");

        // Unmapped offsets and back-to-back accesses
        rd(32'h10, 32'd0, "unmapped_read");
        wr(32'h14, 32'hFFFF_FFFF);
        wr(32'h4, 32'h2B);
        wr(32'h8, 32'h0007_0009);
        wr(32'h0, 32'hA);
        rd(32'h4, 32'h2B, "b2b_addr");
        rd(32'h8, 32'h0007_0009, "b2b_timing");
        rd(32'h0, 32'hA, "b2b_ctrl");

        // Randomised sequences
        for (int n = 0; n < 16; n++) begin
            int   op, row, col, sw, pw;
            logic ien, sa;
            op  = $urandom_range(0, 3);
            row = $urandom_range(0, 7);
            col = $urandom_range(0, 7);
            sw  = $urandom_range(0, 6);
            pw  = $urandom_range(0, 6);
            ien = 1'($urandom_range(0, 1));
            sa  = 1'($urandom_range(0, 1));
            run_seq(op, row, col, sw, pw, ien, sa);
            check("rand_irq", irq, ien);
            check("rand_idle_mode", op_mode, 2'd0);
            rd(32'h0, 32'(op | (ien << 3)), "rand_ctrl_readback");
            wr(32'hC, 32'h2); m_done = 1'b0;
            check("rand_irq_clear", irq, 1'b0);
        end

        // Asynchronous reset in the middle of PULSE
        launch(0, 4, 4, 1, 30, 1'b1, 1'b1);
        wait_pulse();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {wl_sel, bl_sel, pulse_en, sa_en, op_mode, irq}, 21'd0);
        check("async_rst_ack", wb_bus.wbs_ack_o, 1'b0);
        wb_q.delete();
        seq_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_done = 1'b0; m_err = 1'b0; m_rd = 1'b0;
        @(posedge clk); #1;
        rd(32'h0, 32'd0, "post_rst_ctrl");
        rd(32'h4, 32'd0, "post_rst_addr");
        rd(32'h8, 32'd0, "post_rst_timing");
        rd(32'hC, 32'd0, "post_rst_status");

        repeat (2) @(posedge clk);
        check("wb_queue_drained", wb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
